// File: rtl/chaos_key_shift_pkg.sv
// Shared register map, bit indices and FSM state encoding for the chaos key-shift scheduler.
package chaos_key_shift_pkg;

    localparam logic [1:0] ADDR_SHIFT  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FLUSH  = 2;

    localparam int unsigned ST_FULL     = 8;
    localparam int unsigned ST_EMPTY    = 9;
    localparam int unsigned ST_OVERFLOW = 16;
    localparam int unsigned ST_DRAINED  = 17;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/chaos_key_shift_fifo.sv
// Pending key-shift word FIFO; flush wins over push/pop, a full push is accepted only alongside a pop.
module chaos_key_shift_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/chaos_key_shift_sched.sv
// Avalon-MM programmed scheduler presenting queued key-shift words after a programmable period.
// Define CHAOS_KEY_SHIFT_SCHED_IRQ_EN to enable the irq_en control bit and the level interrupt.
module chaos_key_shift_sched
    import chaos_key_shift_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] key_shift,
    output logic              shift_valid,
    input  logic              shift_ack,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t              state;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] wait_cnt;
    logic                enable;
    logic                irq_en;
    logic                overflow;
    logic                drained;

    logic [DATA_W-1:0]   head;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    count;

    logic wr;
    logic ctrl_wr;
    logic status_wr;
    logic push_c;
    logic pop_c;
    logic flush_c;
    logic push_ok;
    logic irq_en_d;
    logic ovf_d;
    logic drn_d;
    logic irq_d;

    // Bus decode, FIFO handshakes and next values of the sticky flags.
    always_comb begin
        wr        = chipselect & ~write_n;
        ctrl_wr   = wr & (address == ADDR_CTRL);
        status_wr = wr & (address == ADDR_STATUS);
        push_c    = wr & (address == ADDR_SHIFT);
        flush_c   = ctrl_wr & writedata[CTRL_FLUSH];
        pop_c     = (state == S_WAIT) & enable & (wait_cnt == '0) & ~empty & ~flush_c;
        push_ok   = push_c & ~flush_c & (~full | pop_c);
        ovf_d     = (push_c & ~flush_c & full & ~pop_c)
                  | (overflow & ~(status_wr & writedata[ST_OVERFLOW]));
        drn_d     = (pop_c & ~push_ok & (count == CNT_W'(1)))
                  | (drained & ~(status_wr & writedata[ST_DRAINED]));
`ifdef CHAOS_KEY_SHIFT_SCHED_IRQ_EN
        irq_en_d  = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en;
`else
        irq_en_d  = 1'b0;
`endif
        irq_d     = irq_en_d & (ovf_d | drn_d);
    end

    chaos_key_shift_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .pop     (pop_c),
        .flush   (flush_c),
        .wdata   (writedata),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Control registers, sticky flags and the IDLE/WAIT/PRESENT scheduler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            period      <= '0;
            wait_cnt    <= '0;
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            overflow    <= 1'b0;
            drained     <= 1'b0;
            irq         <= 1'b0;
            key_shift   <= '0;
            shift_valid <= 1'b0;
        end else begin
            irq_en   <= irq_en_d;
            overflow <= ovf_d;
            drained  <= drn_d;
            irq      <= irq_d;
            if (ctrl_wr) begin
                enable <= writedata[CTRL_ENABLE];
            end
            if (wr && address == ADDR_PERIOD) begin
                period <= writedata[PERIOD_W-1:0];
            end

            if (flush_c) begin
                state       <= S_IDLE;
                shift_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (enable && !empty) begin
                            wait_cnt <= period;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!enable) begin
                            state <= S_IDLE;
                        end else if (pop_c) begin
                            key_shift   <= head;
                            shift_valid <= 1'b1;
                            state       <= S_PRESENT;
                        end else if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - PERIOD_W'(1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PRESENT: begin
                        if (shift_ack) begin
                            shift_valid <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        shift_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Zero wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_SHIFT: readdata = key_shift;
            ADDR_CTRL: begin
                readdata[CTRL_ENABLE] = enable;
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
            ADDR_STATUS: begin
                readdata[7:0]         = 8'(count);
                readdata[ST_FULL]     = full;
                readdata[ST_EMPTY]    = empty;
                readdata[ST_OVERFLOW] = overflow;
                readdata[ST_DRAINED]  = drained;
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_chaos_key_shift_sched.sv
// Randomized bench for chaos_key_shift_sched: queue-based reference model plus presentation scoreboard.
module tb_chaos_key_shift_sched;

    localparam int unsigned DEPTH = 4;
    localparam logic [1:0] A_SHIFT  = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] key_shift;
    logic        shift_valid;
    logic        shift_ack;
    logic        irq;

    int n_chk;
    int n_pass;

    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic        m_ovf;
    logic        m_drn;
    logic [31:0] last_key;

    chaos_key_shift_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .key_shift   (key_shift),
        .shift_valid (shift_valid),
        .shift_ack   (shift_ack),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Reference model: plain queue with the map's status arithmetic.
    task automatic m_push(input logic [31:0] w);
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else begin
            mq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic m_pop();
        last_key = mq.pop_front();
        if (mq.size() == 0) m_drn = 1'b1;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size());
        if (mq.size() == DEPTH) s[8] = 1'b1;
        if (mq.size() == 0) s[9] = 1'b1;
        s[16] = m_ovf;
        s[17] = m_drn;
        return s;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        m_push(w);
        wr(A_SHIFT, w);
    endtask

    task automatic wait_sv(output int cyc);
        cyc = 0;
        while (!shift_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!shift_valid) begin
            n_chk++;
            $display("FAIL present_timeout: shift_valid 0 after %0d cycles, required 1", cyc);
        end
    endtask

    task automatic ack(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        shift_ack = 1'b1;
        @(posedge clk); #1;
        shift_ack = 1'b0;
        chk("valid_drop", 32'(shift_valid), 32'd0);
    endtask

    // Wait for the next word (period p rule: p+2 cycles from the triggering edge), then accept it.
    task automatic present_ack(input int p);
        int c;
        wait_sv(c);
        chk("latency", 32'(c), 32'(p + 2));
        m_pop();
        ack($urandom_range(0, 3));
    endtask

    // Scoreboard monitor: every new presentation must match the oldest accepted word and hold stable.
    logic        prev_sv;
    logic [31:0] held;
    always @(negedge clk) begin
        if (!reset_n) prev_sv = 1'b0;
        else begin
            if (shift_valid && !prev_sv) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_present: key_shift 0x%08h with no word pending", key_shift);
                end else chk("present_word", key_shift, exp_q.pop_front());
                held = key_shift;
            end else if (shift_valid) begin
                chk("present_stable", key_shift, held);
            end
            prev_sv = shift_valid;
        end
    end

    initial begin
        int c;
        int p;
        int k;
        logic [31:0] w;
        logic seen;
        n_chk = 0; n_pass = 0;
        m_ovf = 1'b0; m_drn = 1'b0; last_key = '0;
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; shift_ack = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(shift_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_status", A_STATUS, 32'h200);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_period", A_PERIOD, 32'h0);
        rd_chk("rst_key", A_SHIFT, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // PERIOD register width
        wr(A_PERIOD, 32'hFFFF_1234);
        rd_chk("period_upper", A_PERIOD, 32'h0000_1234);

        // Basic PERIOD=3 presentation and hold
        wr(A_PERIOD, 32'd3);
        push_word(32'hA5A5_0001);
        wr(A_CTRL, 32'h1);
        wait_sv(c);
        chk("s1_latency", 32'(c), 32'd5);
        chk("s1_key", key_shift, 32'hA5A5_0001);
        m_pop();
        repeat (3) begin @(posedge clk); #1; end
        chk("s1_hold_valid", 32'(shift_valid), 32'd1);
        ack(0);
        rd_chk("s1_status", A_STATUS, m_status());
        wr(A_STATUS, 32'h2_0000); m_drn = 1'b0;
        wr(A_CTRL, 32'h0);

        // Random periods, data, burst sizes and ack delays
        for (int r = 0; r < 6; r++) begin
            p = $urandom_range(0, 6);
            k = $urandom_range(1, 3);
            wr(A_PERIOD, 32'(p));
            for (int j = 0; j < k; j++) push_word($urandom);
            rd_chk("rnd_status_pre", A_STATUS, m_status());
            wr(A_CTRL, 32'h1);
            for (int j = 0; j < k; j++) present_ack(p);
            rd_chk("rnd_status_post", A_STATUS, m_status());
            wr(A_STATUS, 32'h2_0000); m_drn = 1'b0;
            wr(A_CTRL, 32'h0);
        end

        // Overflow: fifth push dropped and never presented
        wr(A_PERIOD, 32'd0);
        for (int j = 0; j < 5; j++) push_word($urandom);
        rd_chk("s2_status_full", A_STATUS, m_status());
        wr(A_CTRL, 32'h1);
        for (int j = 0; j < 4; j++) present_ack(0);
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (shift_valid) seen = 1'b1; end
        chk("s2_no_fifth", 32'(seen), 32'd0);
        rd_chk("s2_status_drained", A_STATUS, m_status());
        wr(A_STATUS, 32'h3_0000); m_ovf = 1'b0; m_drn = 1'b0;
        rd_chk("s2_status_clear", A_STATUS, m_status());
        wr(A_CTRL, 32'h0);

        // Push into a full FIFO on the same edge as a pop
        for (int j = 0; j < 4; j++) push_word($urandom);
        wr(A_PERIOD, 32'd2);
        wr(A_CTRL, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        w = $urandom;
        wr(A_SHIFT, w);
        chk("s3_pop_edge", 32'(shift_valid), 32'd1);
        m_pop();
        m_push(w);
        rd_chk("s3_status", A_STATUS, m_status());
        ack($urandom_range(0, 2));
        for (int j = 0; j < 4; j++) present_ack(2);
        rd_chk("s3_status_end", A_STATUS, m_status());
        wr(A_STATUS, 32'h2_0000); m_drn = 1'b0;
        wr(A_CTRL, 32'h0);

        // Flush during WAIT with two words queued
        wr(A_PERIOD, 32'd10);
        push_word($urandom);
        push_word($urandom);
        wr(A_CTRL, 32'h1);
        repeat (3) begin @(posedge clk); #1; end
        wr(A_CTRL, 32'h5);
        mq.delete();
        exp_q.delete();
        seen = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (shift_valid) seen = 1'b1; end
        chk("s4_no_pulse", 32'(seen), 32'd0);
        rd_chk("s4_status", A_STATUS, m_status());
        rd_chk("s4_key_kept", A_SHIFT, last_key);
        rd_chk("s4_ctrl_flush_reads0", A_CTRL, 32'h1);
        wr(A_PERIOD, 32'd2);
        push_word($urandom);
        present_ack(2);
        wr(A_STATUS, 32'h2_0000); m_drn = 1'b0;
        wr(A_CTRL, 32'h0);

        // Drained interrupt
        wr(A_CTRL, 32'h3);
`ifdef CHAOS_KEY_SHIFT_SCHED_IRQ_EN
        rd_chk("s5_ctrl", A_CTRL, 32'h3);
`else
        rd_chk("s5_ctrl", A_CTRL, 32'h1);
`endif
        wr(A_PERIOD, 32'd0);
        push_word($urandom);
        present_ack(0);
`ifdef CHAOS_KEY_SHIFT_SCHED_IRQ_EN
        chk("s5_irq_set", 32'(irq), 32'd1);
`else
        chk("s5_irq_set", 32'(irq), 32'd0);
`endif
        rd_chk("s5_status", A_STATUS, m_status());
        wr(A_STATUS, 32'h2_0000); m_drn = 1'b0;
        chk("s5_irq_clear", 32'(irq), 32'd0);
        rd_chk("s5_status_clear", A_STATUS, m_status());
        wr(A_CTRL, 32'h0);

        // Reset in the middle of a handshake
        wr(A_PERIOD, 32'd1);
        push_word(32'h5A5A_BEEF);
        wr(A_CTRL, 32'h1);
        wait_sv(c);
        chk("s6_latency", 32'(c), 32'd3);
        m_pop();
        repeat (2) begin @(posedge clk); #1; end
        chk("s6_presenting", 32'(shift_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_valid", 32'(shift_valid), 32'd0);
        chk("s6_key", key_shift, 32'h0);
        chk("s6_irq", 32'(irq), 32'd0);
        rd_chk("s6_status", A_STATUS, 32'h200);
        rd_chk("s6_ctrl", A_CTRL, 32'h0);
        mq.delete(); exp_q.delete(); m_ovf = 1'b0; m_drn = 1'b0; last_key = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        push_word($urandom);
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (shift_valid) seen = 1'b1; end
        chk("s6_idle_after_reset", 32'(seen), 32'd0);
        rd_chk("s6_status_after", A_STATUS, m_status());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/chaos_key_shift_sched.md
CHAOS_KEY_SHIFT_SCHED -- requirements
Module: chaos_key_shift_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the key-shift word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two): number of pending shift words.
REQ-003 SHALL have parameter PERIOD_W, default 16: width of the inter-application period counter.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports address (input, 2 bits), chipselect (input, 1 bit), write_n (input, 1 bit, active-low) and writedata (input, DATA_W bits): Avalon-MM slave write side.
REQ-007 SHALL have port readdata, output, DATA_W bits: combinational, zero wait-state read mux.
REQ-008 SHALL have port key_shift, output, DATA_W bits: currently applied key-shift word.
REQ-009 SHALL have port shift_valid, output, 1 bit: a new key_shift is presented to the chaos datapath.
REQ-010 SHALL have port shift_ack, input, 1 bit: the datapath accepts key_shift.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-012 A write occurs when chipselect=1 and write_n=0; the register map SHALL be: 0 SHIFT (write pushes FIFO, read returns key_shift), 1 CTRL, 2 PERIOD, 3 STATUS.
REQ-013 CTRL SHALL contain bit0 enable, bit1 irq_en and bit2 flush; flush is write-only, self-clearing and reads 0.
REQ-014 PERIOD[PERIOD_W-1:0] SHALL set the wait in cycles between leaving IDLE and presenting a word; the upper bits SHALL read 0.
REQ-015 STATUS SHALL contain: [7:0] fill count, bit8 full, bit9 empty, bit16 overflow (sticky, write-1-to-clear), bit17 drained (sticky, write-1-to-clear).
REQ-016 The FSM SHALL have states IDLE, WAIT and PRESENT.
REQ-017 IDLE->WAIT SHALL occur when enable=1 and the FIFO is not empty, loading the counter with PERIOD.
REQ-018 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL pop the FIFO head into key_shift, set shift_valid and go to PRESENT, so PERIOD=N gives N+1 cycles from IDLE exit to shift_valid.
REQ-019 In PRESENT, shift_valid and key_shift SHALL hold stable until shift_ack=1, then shift_valid SHALL drop the next cycle and the FSM SHALL return to IDLE.
REQ-020 enable=0 in WAIT SHALL return the FSM to IDLE with no pop; enable=0 in PRESENT SHALL NOT abort the handshake.
REQ-021 A push to a full FIFO SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-022 A pop that leaves the FIFO empty SHALL set drained.
REQ-023 flush SHALL empty the FIFO, force IDLE and clear shift_valid, retain key_shift, and take priority over a same-cycle push or pop.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL saturate at FIFO_DEPTH.

Reset
REQ-025 While reset_n=0: key_shift=0, shift_valid=0, irq=0, FIFO empty, FSM=IDLE, and CTRL, PERIOD, overflow and drained SHALL all be 0.
REQ-026 Reset asserted mid-handshake SHALL abandon it immediately, with no pending state retained.

Configuration
REQ-027 Macro CHAOS_KEY_SHIFT_SCHED_IRQ_EN defined: irq = irq_en AND (drained OR overflow).
REQ-028 Macro CHAOS_KEY_SHIFT_SCHED_IRQ_EN undefined: irq is tied 0, CTRL bit1 SHALL read 0 and ignore writes, and the sticky STATUS bits SHALL still function.

Structure
REQ-029 A shared package chaos_key_shift_pkg SHALL hold the register address constants, the CTRL/STATUS bit indices and the FSM state enum.
REQ-030 The FIFO SHALL be a sub-module chaos_key_shift_fifo (push, pop, flush, full, empty, count).

Verification
REQ-031 Scenario: PERIOD=3, push 0xA5A5_0001, enable=1 -> shift_valid rises 4 cycles after IDLE exit, key_shift=0xA5A5_0001, and it holds until shift_ack.
REQ-032 Scenario: push 5 words with FIFO_DEPTH=4 and enable=0 -> count=4, full=1, overflow=1, and the 5th word is never presented.
REQ-033 Scenario: full FIFO with a same-cycle push and pop -> push accepted, count stays 4, overflow stays 0.
REQ-034 Scenario: flush during WAIT with 2 queued -> FSM=IDLE, empty=1, key_shift unchanged, no shift_valid pulse.
REQ-035 Scenario: irq_en=1 with the IRQ macro defined, pop the last word -> drained=1 and irq=1; writing STATUS 0x20000 -> irq=0.
REQ-036 Scenario: reset_n pulsed low during PRESENT -> shift_valid=0, key_shift=0, STATUS reads 0x200.
